// File: rtl/mio_pkg.sv
// Shared types and address map for the memory/IO responder.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_SW,
    REG_LED,
    REG_CNT,
    REG_NONE
  } region_e;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK = 32'hFFFF_F000;
  localparam logic [31:0] SW_ADDR  = 32'hE000_0000;
  localparam logic [31:0] LED_ADDR = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR = 32'hF000_0004;

  function automatic logic [3:0] wait_cycles(region_e r, logic [3:0] ram_w, logic [3:0] io_w);
    case (r)
      REG_RAM:                   return ram_w;
      REG_SW, REG_LED, REG_CNT:  return io_w;
      default:                   return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// Full 32-bit address decode into a bus region.
module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [31:0] addr,
  output region_e     region
);

  always_comb begin
    region = REG_NONE;
    if ((addr & RAM_MASK) == RAM_BASE) region = REG_RAM;
    else if (addr == SW_ADDR)          region = REG_SW;
    else if (addr == LED_ADDR)         region = REG_LED;
    else if (addr == CNT_ADDR)         region = REG_CNT;
  end

endmodule

// File: rtl/mio_responder.sv
// Memory/IO responder: latches one CPU request, waits a per-region number
// of cycles, then pulses MIO_ready with read data and commits any store.
module mio_responder
  import mio_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        MIO_ready,
  output logic        bus_err,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
  localparam logic [3:0] IO_W  = 4'(IO_WAIT);

  state_e      state_q,  state_d;
  region_e     region_q, region_d, dec_region;
  logic [9:0]  word_q,   word_d;
  logic [31:0] wdata_q,  wdata_d;
  logic        we_q,     we_d;
  logic [3:0]  wcnt_q,   wcnt_d;
  logic [15:0] led_q,    led_d;
  logic [31:0] cnt_q,    cnt_d;

  mio_addr_decode u_decode (
    .addr   (addr),
    .region (dec_region)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    wcnt_d    = wcnt_q;
    led_d     = led_q;
    cnt_d     = cnt_q + 32'd1;
    MIO_ready = 1'b0;
    bus_err   = 1'b0;
    ram_we    = 1'b0;
    rdata     = '0;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          region_d = dec_region;
          word_d   = addr[11:2];
          wdata_d  = wdata;
          we_d     = mem_w;
          wcnt_d   = wait_cycles(dec_region, RAM_W, IO_W);
          state_d  = (wcnt_d != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_d == 4'd0) state_d = RESP;
      end
      RESP: begin
        MIO_ready = 1'b1;
        bus_err   = (region_q == REG_NONE);
        state_d   = IDLE;
        if (we_q) begin
          // A counter store overrides this cycle's increment.
          case (region_q)
            REG_RAM: ram_we = 1'b1;
            REG_LED: led_d  = wdata_q[15:0];
            REG_CNT: cnt_d  = wdata_q;
            default: ;
          endcase
        end else begin
          case (region_q)
            REG_RAM: rdata = ram_dout;
            REG_SW:  rdata = {16'h0, sw};
            REG_LED: rdata = {16'h0, led_q};
            REG_CNT: rdata = cnt_q;
            default: rdata = '0;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      region_q <= REG_RAM;
      word_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      wcnt_q   <= '0;
      led_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      wcnt_q   <= wcnt_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ram_addr = word_q;
  assign ram_din  = wdata_q;
  assign led      = led_q;

endmodule
